// File: rtl/ppb_io_mapper_if.sv
// Board-side signal bundle for ppb_io_mapper.
// There is no handshake on this bundle: every signal is a plain level or a
// one-cycle pulse sampled on the mapper clock. The "slave" modport is the
// mapper itself; the "master" modport is the board/CPU side that drives the
// raw pins and probe bus and observes the mapped outputs.
interface ppb_io_mapper_if #(
  parameter int DEV_IN_W  = 60,
  parameter int DEV_OUT_W = 120,
  parameter int PROBE_W   = 240
);
  localparam int PAGES  = (PROBE_W + DEV_OUT_W - 1) / DEV_OUT_W;
  localparam int PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1;

  logic [0:DEV_IN_W-1]  device_inputs;
  logic [0:PROBE_W-1]   probe_bus;
  logic [0:DEV_OUT_W-1] device_outputs;
  logic                 clk_auto_en;
  logic                 clk_step;
  logic                 reset_req;
  logic [0:DEV_IN_W-6]  user_inputs;
  logic [PAGE_W-1:0]    page_sel;
  logic                 frozen;

  modport slave (
    input  device_inputs, probe_bus,
    output device_outputs, clk_auto_en, clk_step, reset_req,
           user_inputs, page_sel, frozen
  );

  modport master (
    output device_inputs, probe_bus,
    input  device_outputs, clk_auto_en, clk_step, reset_req,
           user_inputs, page_sel, frozen
  );
endinterface

// File: rtl/ppb_io_mapper.sv
// Registered peripheral-board pin mapper.
// Synchronises every board pin, debounces the five control pins, turns the
// step button into a one-cycle pulse (suppressed while auto-clock is on),
// and pages the wide probe bus onto the output pins with a freeze/snapshot
// mode. The design is pure datapath: no FSM, all state is in *_q registers.
module ppb_io_mapper #(
  parameter int DEV_IN_W    = 60,
  parameter int DEV_OUT_W   = 120,
  parameter int PROBE_W     = 240,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 1000
) (
  input  logic            clk,
  input  logic            reset,
  ppb_io_mapper_if.slave  bus
);
  localparam int PAGES  = (PROBE_W + DEV_OUT_W - 1) / DEV_OUT_W;
  localparam int PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int EXT_W  = PAGES * DEV_OUT_W;
  localparam int CNT_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int NDEB   = 5;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGES - 1);

  // Control pin positions on device_inputs.
  localparam int B_AUTO = 0;
  localparam int B_STEP = 1;
  localparam int B_RST  = 2;
  localparam int B_FRZ  = 3;
  localparam int B_PAGE = 4;

  // Synchroniser chain; stage 0 is closest to the pins.
  logic [SYNC_STAGES-1:0][0:DEV_IN_W-1] sync_q, sync_d;
  logic [0:DEV_IN_W-1]                  sync_in;

  // Debounce state for bits 0..4, plus one cycle of edge history.
  logic [0:NDEB-1]            stable_q, stable_d;
  logic [0:NDEB-1]            prev_q;
  logic [0:NDEB-1][CNT_W-1:0] cnt_q, cnt_d;

  logic                 clk_step_q, clk_step_d;
  logic [PAGE_W-1:0]    page_q, page_d;
  logic [0:DEV_OUT_W-1] dout_q, dout_d;

  logic                 step_rise, page_rise, frozen_w, auto_w;
  logic [0:EXT_W-1]     probe_ext;
  logic [0:DEV_OUT_W-1] page_vec;

  assign sync_d  = {sync_q[SYNC_STAGES-2:0], bus.device_inputs};
  assign sync_in = sync_q[SYNC_STAGES-1];

  // Debounce filter: a differing level must persist DEB_CYCLES cycles.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int b = 0; b < NDEB; b++) begin
      if (sync_in[b] == stable_q[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] == CNT_LAST) begin
        stable_d[b] = sync_in[b];
        cnt_d[b]    = '0;
      end else begin
        cnt_d[b] = cnt_q[b] + CNT_W'(1);
      end
    end
  end

  assign auto_w    = stable_q[B_AUTO];
  assign frozen_w  = stable_q[B_FRZ];
  assign step_rise = stable_q[B_STEP] & ~prev_q[B_STEP];
  assign page_rise = stable_q[B_PAGE] & ~prev_q[B_PAGE];

  // Step pulse, page pointer and paged/frozen output selection.
  always_comb begin
    clk_step_d = step_rise & ~auto_w;

    page_d = page_q;
    if (page_rise && !frozen_w) begin
      page_d = (page_q == PAGE_LAST) ? '0 : page_q + PAGE_W'(1);
    end

    // Pad the probe bus to whole pages so indices past PROBE_W read as 0.
    probe_ext              = '0;
    probe_ext[0:PROBE_W-1] = bus.probe_bus;

    page_vec = '0;
    for (int p = 0; p < PAGES; p++) begin
      if (page_q == PAGE_W'(p)) begin
        page_vec = probe_ext[p*DEV_OUT_W +: DEV_OUT_W];
      end
    end

    dout_d = frozen_w ? dout_q : page_vec;
  end

  // All state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      stable_q   <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      clk_step_q <= 1'b0;
      page_q     <= '0;
      dout_q     <= '0;
    end else begin
      sync_q     <= sync_d;
      stable_q   <= stable_d;
      prev_q     <= stable_q;
      cnt_q      <= cnt_d;
      clk_step_q <= clk_step_d;
      page_q     <= page_d;
      dout_q     <= dout_d;
    end
  end

  assign bus.device_outputs = dout_q;
  assign bus.clk_auto_en    = stable_q[B_AUTO];
  assign bus.clk_step       = clk_step_q;
  assign bus.reset_req      = stable_q[B_RST];
  assign bus.frozen         = stable_q[B_FRZ];
  assign bus.page_sel       = page_q;
  assign bus.user_inputs    = sync_in[5:DEV_IN_W-1];
endmodule

// File: tb/tb_ppb_io_mapper.sv
// Directed bench for ppb_io_mapper with DEB_CYCLES=4, SYNC_STAGES=2,
// PROBE_W=250, DEV_OUT_W=120 (three pages, last one partly empty).
module tb_ppb_io_mapper;
  localparam int DIW = 8;
  localparam int DOW = 120;
  localparam int PW  = 250;
  localparam int SS  = 2;
  localparam int DC  = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ppb_io_mapper_if #(.DEV_IN_W(DIW), .DEV_OUT_W(DOW), .PROBE_W(PW)) bus();

  ppb_io_mapper #(
    .DEV_IN_W(DIW), .DEV_OUT_W(DOW), .PROBE_W(PW),
    .SYNC_STAGES(SS), .DEB_CYCLES(DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int passed   = 0;
  int total    = 0;
  int exp_page = 0;

  // ---------------- helpers / driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [0:PW-1] ramp(input int seed);
    logic [0:PW-1] r;
    int v;
    for (int i = 0; i < PW; i++) begin
      v    = ((i / 8) + seed) & 255;
      r[i] = v[i % 8];
    end
    return r;
  endfunction

  function automatic logic [0:DOW-1] page_model(input logic [0:PW-1] p, input int pg);
    logic [0:DOW-1] r;
    int idx;
    for (int i = 0; i < DOW; i++) begin
      idx = pg * DOW + i;
      if (idx < PW) r[i] = p[idx];
      else          r[i] = 1'b0;
    end
    return r;
  endfunction

  task automatic watch_step(input int n, output int pulses, output int first_at);
    pulses   = 0;
    first_at = -1;
    for (int k = 1; k <= n; k++) begin
      tick(1);
      if (bus.clk_step === 1'b1) begin
        pulses++;
        if (first_at < 0) first_at = k;
      end
    end
  endtask

  task automatic press(input int b, input int hold, input int settle);
    bus.device_inputs[b] = 1'b1;
    tick(hold);
    bus.device_inputs[b] = 1'b0;
    tick(settle);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [0:DOW-1] exp_o;
    reset             = 1'b1;
    bus.device_inputs = '0;
    bus.probe_bus     = ramp(0);
    tick(3);
    total++;
    if (bus.device_outputs !== '0) $display("FAIL reset_outputs: got %h expected 0", bus.device_outputs);
    else passed++;
    total++;
    if (bus.page_sel !== 2'd0) $display("FAIL reset_page: got %0d expected 0", bus.page_sel);
    else passed++;
    total++;
    if ({bus.clk_step, bus.clk_auto_en, bus.reset_req, bus.frozen, bus.user_inputs} !== 7'd0)
      $display("FAIL reset_levels: got %b expected 0000000",
               {bus.clk_step, bus.clk_auto_en, bus.reset_req, bus.frozen, bus.user_inputs});
    else passed++;

    reset = 1'b0;
    tick(1);
    exp_o = page_model(ramp(0), 0);
    total++;
    if (bus.device_outputs !== exp_o) $display("FAIL first_load: got %h expected %h", bus.device_outputs, exp_o);
    else passed++;

    bus.probe_bus = ramp(17);
    tick(1);
    exp_o = page_model(ramp(17), 0);
    total++;
    if (bus.device_outputs !== exp_o) $display("FAIL probe_latency: got %h expected %h", bus.device_outputs, exp_o);
    else passed++;
    exp_page = 0;
  endtask

  task automatic test_user_inputs();
    bus.device_inputs[5:7] = 3'b101;
    tick(1);
    total++;
    if (bus.user_inputs !== 3'b000) $display("FAIL user_early: got %b expected 000", bus.user_inputs);
    else passed++;
    tick(1);
    total++;
    if (bus.user_inputs !== 3'b101) $display("FAIL user_sync: got %b expected 101", bus.user_inputs);
    else passed++;
    bus.device_inputs[5:7] = 3'b010;
    tick(2);
    total++;
    if (bus.user_inputs !== 3'b010) $display("FAIL user_sync2: got %b expected 010", bus.user_inputs);
    else passed++;
  endtask

  task automatic test_step_clean();
    int p, f;
    bus.device_inputs[1] = 1'b1;
    watch_step(10, p, f);
    total++;
    if (p !== 1) $display("FAIL step_count: got %0d expected 1", p);
    else passed++;
    total++;
    if (f !== SS + DC + 1) $display("FAIL step_latency: got %0d expected %0d", f, SS + DC + 1);
    else passed++;
    bus.device_inputs[1] = 1'b0;
    tick(10);
  endtask

  task automatic test_step_glitch();
    int p, f;
    bus.device_inputs[1] = 1'b1;
    tick(3);
    bus.device_inputs[1] = 1'b0;
    watch_step(12, p, f);
    total++;
    if (p !== 0) $display("FAIL glitch_pulse: got %0d expected 0", p);
    else passed++;
  endtask

  task automatic test_auto_en();
    int p, f;
    bus.device_inputs[0] = 1'b1;
    tick(8);
    total++;
    if (bus.clk_auto_en !== 1'b1) $display("FAIL auto_en_on: got %b expected 1", bus.clk_auto_en);
    else passed++;
    bus.device_inputs[1] = 1'b1;
    watch_step(10, p, f);
    total++;
    if (p !== 0) $display("FAIL auto_blocks_step: got %0d expected 0", p);
    else passed++;
    bus.device_inputs[1] = 1'b0;
    tick(8);
    bus.device_inputs[0] = 1'b0;
    tick(8);
    total++;
    if (bus.clk_auto_en !== 1'b0) $display("FAIL auto_en_off: got %b expected 0", bus.clk_auto_en);
    else passed++;
    bus.device_inputs[1] = 1'b1;
    watch_step(10, p, f);
    total++;
    if (p !== 1) $display("FAIL step_after_auto: got %0d expected 1", p);
    else passed++;
    bus.device_inputs[1] = 1'b0;
    tick(8);
  endtask

  task automatic test_paging();
    logic [0:DOW-1] exp_o;
    bus.probe_bus = ramp(40);
    press(4, 8, 8);
    exp_page = 1;
    total++;
    if (bus.page_sel !== 2'd1) $display("FAIL page_to_1: got %0d expected 1", bus.page_sel);
    else passed++;
    exp_o = page_model(ramp(40), 1);
    total++;
    if (bus.device_outputs !== exp_o) $display("FAIL page1_data: got %h expected %h", bus.device_outputs, exp_o);
    else passed++;

    press(4, 8, 8);
    exp_page = 2;
    total++;
    if (bus.page_sel !== 2'd2) $display("FAIL page_to_2: got %0d expected 2", bus.page_sel);
    else passed++;
    exp_o = page_model(ramp(40), 2);
    total++;
    if (bus.device_outputs[0:9] !== exp_o[0:9])
      $display("FAIL page2_low: got %h expected %h", bus.device_outputs[0:9], exp_o[0:9]);
    else passed++;
    total++;
    if (bus.device_outputs[10:119] !== '0)
      $display("FAIL page2_pad: got %h expected 0", bus.device_outputs[10:119]);
    else passed++;

    press(4, 8, 8);
    exp_page = 0;
    total++;
    if (bus.page_sel !== 2'd0) $display("FAIL page_wrap: got %0d expected 0", bus.page_sel);
    else passed++;
  endtask

  task automatic test_freeze();
    logic [0:DOW-1] snap, exp_o;
    press(4, 8, 8);
    exp_page = 1;
    bus.probe_bus = ramp(5);
    tick(2);
    snap = page_model(ramp(5), exp_page);
    bus.device_inputs[3] = 1'b1;
    tick(SS + DC);
    total++;
    if (bus.frozen !== 1'b1) $display("FAIL freeze_on: got %b expected 1", bus.frozen);
    else passed++;
    bus.probe_bus = ramp(99);
    press(4, 8, 8);
    total++;
    if (bus.page_sel !== 2'(exp_page)) $display("FAIL frozen_page: got %0d expected %0d", bus.page_sel, exp_page);
    else passed++;
    total++;
    if (bus.device_outputs !== snap) $display("FAIL frozen_hold: got %h expected %h", bus.device_outputs, snap);
    else passed++;

    bus.device_inputs[3] = 1'b0;
    tick(SS + DC);
    total++;
    if (bus.frozen !== 1'b0) $display("FAIL freeze_off: got %b expected 0", bus.frozen);
    else passed++;
    total++;
    if (bus.device_outputs !== snap) $display("FAIL unfreeze_edge: got %h expected %h", bus.device_outputs, snap);
    else passed++;
    tick(1);
    exp_o = page_model(ramp(99), exp_page);
    total++;
    if (bus.device_outputs !== exp_o) $display("FAIL unfreeze_live: got %h expected %h", bus.device_outputs, exp_o);
    else passed++;
  endtask

  task automatic test_simultaneous();
    int p, f;
    int prev;
    prev = exp_page;
    bus.device_inputs[1] = 1'b1;
    bus.device_inputs[4] = 1'b1;
    watch_step(10, p, f);
    total++;
    if (p !== 1) $display("FAIL simul_step_count: got %0d expected 1", p);
    else passed++;
    total++;
    if (f !== SS + DC + 1) $display("FAIL simul_step_latency: got %0d expected %0d", f, SS + DC + 1);
    else passed++;
    bus.device_inputs[1] = 1'b0;
    bus.device_inputs[4] = 1'b0;
    tick(8);
    exp_page = (prev + 1) % 3;
    total++;
    if (bus.page_sel !== 2'(exp_page)) $display("FAIL simul_page: got %0d expected %0d", bus.page_sel, exp_page);
    else passed++;
  endtask

  task automatic test_reset_mid_debounce();
    bus.device_inputs[2] = 1'b1;
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    exp_page = 0;
    tick(SS + DC - 1);
    total++;
    if (bus.reset_req !== 1'b0) $display("FAIL deb_restart_early: got %b expected 0", bus.reset_req);
    else passed++;
    total++;
    if (bus.page_sel !== 2'd0) $display("FAIL reset_clears_page: got %0d expected 0", bus.page_sel);
    else passed++;
    tick(1);
    total++;
    if (bus.reset_req !== 1'b1) $display("FAIL deb_restart_done: got %b expected 1", bus.reset_req);
    else passed++;
    bus.device_inputs[2] = 1'b0;
    tick(8);
    total++;
    if (bus.reset_req !== 1'b0) $display("FAIL reset_req_release: got %b expected 0", bus.reset_req);
    else passed++;
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_user_inputs();
    test_step_clean();
    test_step_glitch();
    test_auto_en();
    test_paging();
    test_freeze();
    test_simultaneous();
    test_reset_mid_debounce();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ppb_io_mapper.md
# ppb_io_mapper

Parametrised, registered successor to the combinational peripheral-board pin mapper. It sits between the physical peripheral-board pins and the CPU core. It synchronises and debounces board inputs, and turns the step button into a single-cycle pulse. It pages a wide internal probe bus onto the limited output pins, with a freeze (snapshot) mode for inspecting CPU state while the clock runs.

## Interface
Parameters:
- DEV_IN_W, 60, number of board input pins (min 5)
- DEV_OUT_W, 120, number of board output pins
- PROBE_W, 240, width of internal probe bus (any value ≥ 1)
- SYNC_STAGES, 2, synchroniser depth on every input pin (min 2)
- DEB_CYCLES, 1000, debounce filter length in clk cycles (min 1)

Ports:
- clk  in  1  system clock; one clock domain only
- reset  in  1  synchronous, active-high reset
- device_inputs  in  [0:DEV_IN_W-1]  raw board pins: bit0 auto-clock enable, bit1 step button, bit2 reset request, bit3 freeze switch, bit4 page-advance button, bits 5.. general user inputs
- probe_bus  in  [0:PROBE_W-1]  concatenated CPU state to display (bus, registers, flags, control signals)
- device_outputs  out  [0:DEV_OUT_W-1]  registered board output pins
- clk_auto_en  out  1  debounced level of bit0
- clk_step  out  1  single-cycle step pulse
- reset_req  out  1  debounced level of bit2
- user_inputs  out  [0:DEV_IN_W-6]  synchronised (not debounced) bits 5..DEV_IN_W-1
- page_sel  out  max(1,$clog2(PAGES))  current output page
- frozen  out  1  debounced level of bit3

## Operation
- PAGES = ceil(PROBE_W / DEV_OUT_W).
- Synchroniser: every device_inputs bit passes through a SYNC_STAGES-deep flop chain.
- Debounce: applies to bits 0–4. Each bit has a stable register and a counter.
  - When sync == stable, the counter clears.
  - When sync != stable, the counter increments.
  - On the DEB_CYCLES-th consecutive differing cycle, stable <= sync and the counter clears.
  - DEB_CYCLES=1 means the stable value follows sync with one cycle of delay.
- Edge detect: a rise is stable==1 in the current cycle and 0 in the previous cycle.
- clk_step: goes to 1 for exactly one cycle after a step rise, but only if clk_auto_en is 0 in that cycle. Step rises while auto-enabled are dropped, not queued.
- Paging:
  - A page-advance rise while frozen==0 sets page_sel <= (page_sel==PAGES-1) ? 0 : page_sel+1.
  - A page-advance rise while frozen==1 is ignored.
  - PAGES=1 means page_sel stays 0.
- Output register:
  - When frozen==0, each cycle loads device_outputs[i] <= probe_bus[page_sel*DEV_OUT_W + i].
  - Indices ≥ PROBE_W drive 0.
  - When frozen==1, device_outputs holds its value.
- Step pulses and page rises in the same cycle are handled independently.
- No handshake; all outputs are level or one-cycle pulses.

## Timing
- Reset state: all sync flops, stable values, counters, edge history, page_sel, device_outputs, clk_step, clk_auto_en, reset_req, frozen and user_inputs = 0.
- Reset asserted mid-debounce aborts the count. After reset, the input must again be held DEB_CYCLES cycles.
- Latency from a pin change to user_inputs: SYNC_STAGES cycles.
- Latency from a clean pin change to a debounced level: SYNC_STAGES + DEB_CYCLES cycles.
- clk_step: high one cycle after the stable rise, i.e. SYNC_STAGES + DEB_CYCLES + 1 cycles after a clean press.
- Probe to device_outputs: 1 cycle when not frozen.
- Freeze: the snapshot is the value registered in the cycle before frozen rises. Live update resumes on the first cycle after frozen falls, then takes 1 cycle of output latency.
- Bounce shorter than DEB_CYCLES cycles never changes a stable value.

## Test plan
- Reset, then hold probe_bus = 240-bit ramp -> after reset, device_outputs = 0; 1 cycle after reset release, device_outputs = probe bits 0..119. Cover a reset asserted mid-debounce: count restarts.
- DEB_CYCLES=4, SYNC_STAGES=2, auto_en=0: clean step press -> clk_step high for exactly 1 cycle, 7 cycles after the pin rises. A 3-cycle glitch -> no pulse.
- auto_en held 1 while step is pressed -> clk_step stays 0. Release auto_en, press again -> exactly one pulse.
- PROBE_W=250, DEV_OUT_W=120: three page-advance presses -> page_sel 0→1→2→0. On page 2, device_outputs[0:9] = probe bits 240..249 and [10:119] = 0.
- Freeze on, change probe_bus and press page-advance -> device_outputs and page_sel unchanged. Freeze off -> outputs track probe within 1 cycle of frozen falling.
- Step rise and page-advance rise in the same cycle -> one clk_step pulse and page_sel increments by exactly 1.
